branch_ctrl: RTL and testbench
==============================

Name: branch_ctrl

Overview:
- Sequencer sitting between the execute stage and branch_unit.
- Accepts one branch instruction at a time over a valid/ready handshake and drives branch_unit with latched operands.
- Samples the branch_unit resolution, then issues a pipeline flush and a PC redirect to fetch, held until fetch accepts.
- Owns the return-address stack (RAS) for OP_JSR/OP_RTS and a taken-branch counter.

Parameters:
- RAS_DEPTH, 8, number of return-address entries (power of 2, ≥2).
- CNT_W, 16, width of the taken-branch counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- ex_valid  in  1  branch request valid.
- ex_ready  out  1  controller can accept a request.
- ex_opcode  in  opcode_e  instruction opcode.
- ex_pc  in  32  address of the branch instruction.
- ex_len  in  4  instruction length in bytes.
- ex_operand_a, ex_operand_b  in  16  compare operands.
- ex_v_flag  in  1  V flag.
- ex_target  in  32  decoded branch target.
- bu_opcode  out  opcode_e  to branch_unit.opcode.
- bu_operand_a, bu_operand_b  out  16  to branch_unit.
- bu_v_flag  out  1  to branch_unit.v_flag_in.
- bu_target  out  32  to branch_unit.branch_target.
- bu_taken  in  1  from branch_unit.branch_taken.
- bu_pc  in  32  from branch_unit.branch_pc.
- flush  out  1  one-cycle pipeline flush.
- redirect_valid  out  1  redirect PC valid.
- redirect_pc  out  32  new fetch PC.
- redirect_ready  in  1  fetch accepts redirect.
- ras_count  out  $clog2(RAS_DEPTH)+1  occupied RAS entries.
- ras_overflow  out  1  one-cycle pulse.
- ras_underflow  out  1  one-cycle pulse.
- taken_cnt  out  CNT_W  taken-branch counter.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE.
  - ex_ready=1; flush=0; redirect_valid=0; redirect_pc=0.
  - bu_opcode=OP_NOP; bu_operand_a/b=0; bu_v_flag=0; bu_target=0.
  - RAS emptied, ras_count=0; pulses=0; taken_cnt=0.
  - Reset in any state aborts the operation and drops redirect_valid immediately.
- States: IDLE → ISSUE → RESOLVE → (REDIRECT | IDLE).
- IDLE:
  - ex_ready=1.
  - On ex_valid && ex_ready: latch opcode, pc, len, operands, v_flag, target; go to ISSUE.
- ISSUE:
  - ex_ready=0.
  - bu_* driven from the latches.
  - bu_opcode=OP_NOP for OP_RTS and for non-branch opcodes.
  - branch_unit registers its result at the end of this cycle.
- RESOLVE (bu_taken/bu_pc valid this cycle; bu_* still held):
  - OP_B, BE, BNE, BLT, BGT, BRO: taken = bu_taken; target = bu_pc.
  - OP_JSR: taken = bu_taken (always 1); target = bu_pc.
    - Push ret = ex_pc + zero-extended ex_len, computed mod 2^32.
    - If the RAS is full, the oldest entry is overwritten (circular), ras_count stays RAS_DEPTH, and ras_overflow pulses.
  - OP_RTS:
    - RAS non-empty: pop; taken = 1; target = popped value.
    - RAS empty: taken = 0 and ras_underflow pulses.
  - Other opcodes: taken = 0, no RAS effect.
  - If taken: load redirect_pc, increment taken_cnt (saturates at all-ones), go to REDIRECT.
  - If not taken: go to IDLE.
- REDIRECT:
  - flush=1 in the first REDIRECT cycle only.
  - redirect_valid=1; redirect_pc stable until the handshake.
  - On redirect_valid && redirect_ready: go to IDLE.
  - redirect_ready already high on the first cycle completes in 1 cycle.
- Latency: accept edge E0; RESOLVE spans E1→E2.
  - Taken: redirect_valid/flush first high in the cycle after E2.
  - Not-taken: ex_ready high again after E2 (3-cycle throughput).
- Pulses (ras_overflow, ras_underflow, flush) last exactly one cycle.
- Back-to-back: IDLE re-accepts on the cycle it is entered.

Test Plan:
- Reset mid-REDIRECT with redirect_ready=0 → redirect_valid falls asynchronously; after release, ex_ready=1 and taken_cnt=0.
- OP_BE, a=b=0x1234, target 0x2000, redirect_ready=1 → flush 1-cycle pulse; redirect_valid with redirect_pc=0x2000 three cycles after accept; taken_cnt=1.
- OP_BLT, a=0x0020, b=0x0010 → no flush and no redirect; ex_ready high again three cycles after accept.
- OP_JSR pc=0x1000, len=4, target 0x7000, followed by OP_RTS → redirects 0x7000 then 0x1004; ras_count goes 1 then 0.
- OP_RTS on an empty RAS → ras_underflow pulse, no redirect; 9 JSRs with RAS_DEPTH=8 → ras_overflow on the 9th; 8 RTS then return the 2nd–9th return addresses in LIFO order.
- OP_B with redirect_ready held low 5 cycles → redirect_pc stable and flush only in the first cycle; ex_valid is ignored (ex_ready=0) until the handshake completes.

Source files
------------

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch sequencer between execute and branch_unit, with RAS and taken counter
//
// Purpose: accepts one branch instruction at a time from execute, presents the
// latched operands to branch_unit, samples its resolution, and when taken
// issues a one-cycle flush plus a held PC redirect to fetch. Owns the
// return-address stack used by OP_JSR/OP_RTS and a saturating taken counter.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   ex_valid/ex_ready         request handshake from execute
//   ex_opcode..ex_target      instruction fields latched on accept
//   bu_opcode..bu_target      operands presented to branch_unit
//   bu_taken, bu_pc           branch_unit resolution (valid in RESOLVE)
//   flush                     one-cycle pipeline flush
//   redirect_valid/_ready/_pc PC redirect handshake to fetch
//   ras_count                 occupied RAS entries
//   ras_overflow/_underflow   one-cycle RAS event pulses
//   taken_cnt                 saturating taken-branch counter

package branch_ctrl_pkg;
    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_B   = 4'h1,
        OP_BE  = 4'h2,
        OP_BNE = 4'h3,
        OP_BLT = 4'h4,
        OP_BGT = 4'h5,
        OP_BRO = 4'h6,
        OP_JSR = 4'h7,
        OP_RTS = 4'h8,
        OP_ADD = 4'h9
    } opcode_e;
endpackage

module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int RAS_DEPTH = 8,
    parameter int CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ex_valid,
    output logic                         ex_ready,
    input  opcode_e                      ex_opcode,
    input  logic [31:0]                  ex_pc,
    input  logic [3:0]                   ex_len,
    input  logic [15:0]                  ex_operand_a,
    input  logic [15:0]                  ex_operand_b,
    input  logic                         ex_v_flag,
    input  logic [31:0]                  ex_target,
    output opcode_e                      bu_opcode,
    output logic [15:0]                  bu_operand_a,
    output logic [15:0]                  bu_operand_b,
    output logic                         bu_v_flag,
    output logic [31:0]                  bu_target,
    input  logic                         bu_taken,
    input  logic [31:0]                  bu_pc,
    output logic                         flush,
    output logic                         redirect_valid,
    output logic [31:0]                  redirect_pc,
    input  logic                         redirect_ready,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow,
    output logic [CNT_W-1:0]             taken_cnt
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] RAS_FULL = CW'(RAS_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESOLVE,
        S_REDIRECT
    } state_e;

    state_e      state;
    opcode_e     op_q;
    logic [31:0] pc_q;
    logic [3:0]  len_q;

    // Circular stack: ras_ptr is the next write slot, so a push when full
    // naturally overwrites the oldest entry.
    logic [31:0]   ras_mem [RAS_DEPTH];
    logic [PW-1:0] ras_ptr;
    logic [PW-1:0] ras_top;
    logic [31:0]   ret_addr;

    logic        res_taken;
    logic [31:0] res_target;
    logic        ras_push;
    logic        ras_pop;
    logic        ras_under;

    // branch_unit only sees real conditional/JSR opcodes; RTS is resolved here.
    function automatic opcode_e bu_map(input opcode_e op);
        case (op)
            OP_B, OP_BE, OP_BNE, OP_BLT, OP_BGT, OP_BRO, OP_JSR: bu_map = op;
            default:                                             bu_map = OP_NOP;
        endcase
    endfunction

    assign ras_top  = ras_ptr - PW'(1);
    assign ret_addr = pc_q + {28'd0, len_q};

    always_comb begin
        res_taken  = 1'b0;
        res_target = bu_pc;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        ras_under  = 1'b0;
        case (op_q)
            OP_B, OP_BE, OP_BNE, OP_BLT, OP_BGT, OP_BRO: begin
                res_taken = bu_taken;
            end
            OP_JSR: begin
                res_taken = bu_taken;
                ras_push  = 1'b1;
            end
            OP_RTS: begin
                if (ras_count != '0) begin
                    res_taken  = 1'b1;
                    res_target = ras_mem[ras_top];
                    ras_pop    = 1'b1;
                end else begin
                    ras_under = 1'b1;
                end
            end
            default: begin
                res_taken = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            op_q           <= OP_NOP;
            pc_q           <= '0;
            len_q          <= '0;
            ex_ready       <= 1'b1;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            bu_opcode      <= OP_NOP;
            bu_operand_a   <= '0;
            bu_operand_b   <= '0;
            bu_v_flag      <= 1'b0;
            bu_target      <= '0;
            ras_ptr        <= '0;
            ras_count      <= '0;
            ras_overflow   <= 1'b0;
            ras_underflow  <= 1'b0;
            taken_cnt      <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else begin
            flush         <= 1'b0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;

            case (state)
                S_IDLE: begin
                    // ex_ready is always high in IDLE, so ex_valid alone accepts.
                    if (ex_valid) begin
                        op_q         <= ex_opcode;
                        pc_q         <= ex_pc;
                        len_q        <= ex_len;
                        bu_opcode    <= bu_map(ex_opcode);
                        bu_operand_a <= ex_operand_a;
                        bu_operand_b <= ex_operand_b;
                        bu_v_flag    <= ex_v_flag;
                        bu_target    <= ex_target;
                        ex_ready     <= 1'b0;
                        state        <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    state <= S_RESOLVE;
                end

                S_RESOLVE: begin
                    if (ras_push) begin
                        ras_mem[ras_ptr] <= ret_addr;
                        ras_ptr          <= ras_ptr + PW'(1);
                        if (ras_count == RAS_FULL) begin
                            ras_overflow <= 1'b1;
                        end else begin
                            ras_count <= ras_count + CW'(1);
                        end
                    end
                    if (ras_pop) begin
                        ras_ptr   <= ras_top;
                        ras_count <= ras_count - CW'(1);
                    end
                    if (ras_under) begin
                        ras_underflow <= 1'b1;
                    end

                    if (res_taken) begin
                        redirect_pc    <= res_target;
                        redirect_valid <= 1'b1;
                        flush          <= 1'b1;
                        if (taken_cnt != '1) begin
                            taken_cnt <= taken_cnt + CNT_W'(1);
                        end
                        state <= S_REDIRECT;
                    end else begin
                        ex_ready <= 1'b1;
                        state    <= S_IDLE;
                    end
                end

                S_REDIRECT: begin
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        ex_ready       <= 1'b1;
                        state          <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// tb/tb_branch_ctrl.sv - directed self-checking bench for branch_ctrl

module tb_branch_ctrl;
    import branch_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    opcode_e     ex_opcode;
    logic [31:0] ex_pc;
    logic [3:0]  ex_len;
    logic [15:0] ex_operand_a;
    logic [15:0] ex_operand_b;
    logic        ex_v_flag;
    logic [31:0] ex_target;
    opcode_e     bu_opcode;
    logic [15:0] bu_operand_a;
    logic [15:0] bu_operand_b;
    logic        bu_v_flag;
    logic [31:0] bu_target;
    logic        bu_taken;
    logic [31:0] bu_pc;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic [3:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;
    logic [15:0] taken_cnt;

    int checks = 0;
    int errors = 0;

    branch_ctrl #(.RAS_DEPTH(8), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_opcode      (ex_opcode),
        .ex_pc          (ex_pc),
        .ex_len         (ex_len),
        .ex_operand_a   (ex_operand_a),
        .ex_operand_b   (ex_operand_b),
        .ex_v_flag      (ex_v_flag),
        .ex_target      (ex_target),
        .bu_opcode      (bu_opcode),
        .bu_operand_a   (bu_operand_a),
        .bu_operand_b   (bu_operand_b),
        .bu_v_flag      (bu_v_flag),
        .bu_target      (bu_target),
        .bu_taken       (bu_taken),
        .bu_pc          (bu_pc),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .ras_count      (ras_count),
        .ras_overflow   (ras_overflow),
        .ras_underflow  (ras_underflow),
        .taken_cnt      (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Called on a negedge with the controller idle; returns on the negedge
    // after the accept edge (controller in ISSUE). bu_taken/bu_pc play the
    // branch_unit result and are held through RESOLVE.
    task automatic send(input opcode_e op, input logic [31:0] pc, input logic [3:0] len,
                        input logic [15:0] a, input logic [15:0] b, input logic [31:0] tgt,
                        input logic tk, input logic [31:0] bpc);
        check("accept_ready", ex_ready, 1);
        ex_opcode    = op;
        ex_pc        = pc;
        ex_len       = len;
        ex_operand_a = a;
        ex_operand_b = b;
        ex_v_flag    = 1'b0;
        ex_target    = tgt;
        bu_taken     = tk;
        bu_pc        = bpc;
        ex_valid     = 1'b1;
        step();
        ex_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ret [1:9];

        rst            = 1'b0;
        ex_valid       = 1'b0;
        ex_opcode      = OP_NOP;
        ex_pc          = '0;
        ex_len         = '0;
        ex_operand_a   = '0;
        ex_operand_b   = '0;
        ex_v_flag      = 1'b0;
        ex_target      = '0;
        bu_taken       = 1'b0;
        bu_pc          = '0;
        redirect_ready = 1'b0;

        step();
        step();
        check("rst_ex_ready", ex_ready, 1);
        check("rst_flush", flush, 0);
        check("rst_redirect_valid", redirect_valid, 0);
        check("rst_redirect_pc", redirect_pc, 0);
        check("rst_bu_opcode", bu_opcode, OP_NOP);
        check("rst_bu_target", bu_target, 0);
        check("rst_ras_count", ras_count, 0);
        check("rst_taken_cnt", taken_cnt, 0);
        rst = 1'b1;
        step();

        // Reset in the middle of a stalled redirect.
        send(OP_B, 32'h0000_0100, 4'd2, 16'h0, 16'h0, 32'h3000, 1'b1, 32'h3000);
        step();
        step();
        check("t1_redirect_valid", redirect_valid, 1);
        check("t1_taken_cnt_pre", taken_cnt, 1);
        #2 rst = 1'b0;
        #1;
        check("t1_async_valid_drop", redirect_valid, 0);
        check("t1_async_cnt_clear", taken_cnt, 0);
        step();
        rst = 1'b1;
        step();
        check("t1_ex_ready", ex_ready, 1);
        check("t1_taken_cnt", taken_cnt, 0);

        // Taken BE with fetch ready immediately.
        redirect_ready = 1'b1;
        send(OP_BE, 32'h0000_0200, 4'd4, 16'h1234, 16'h1234, 32'h2000, 1'b1, 32'h2000);
        check("t2_bu_opcode", bu_opcode, OP_BE);
        check("t2_bu_a", bu_operand_a, 16'h1234);
        check("t2_bu_b", bu_operand_b, 16'h1234);
        check("t2_bu_target", bu_target, 32'h2000);
        check("t2_ex_ready_busy", ex_ready, 0);
        step();
        check("t2_resolve_no_flush", flush, 0);
        check("t2_resolve_no_valid", redirect_valid, 0);
        step();
        check("t2_flush", flush, 1);
        check("t2_redirect_valid", redirect_valid, 1);
        check("t2_redirect_pc", redirect_pc, 32'h2000);
        check("t2_taken_cnt", taken_cnt, 1);
        step();
        check("t2_flush_end", flush, 0);
        check("t2_valid_end", redirect_valid, 0);
        check("t2_ex_ready_back", ex_ready, 1);

        // Not-taken BLT: 0x0020 < 0x0010 is false.
        send(OP_BLT, 32'h0000_0300, 4'd4, 16'h0020, 16'h0010, 32'h5000, 1'b0, 32'h0304);
        step();
        check("t3_flush_resolve", flush, 0);
        step();
        check("t3_ex_ready", ex_ready, 1);
        check("t3_no_redirect", redirect_valid, 0);
        check("t3_no_flush", flush, 0);
        check("t3_taken_cnt", taken_cnt, 1);

        // JSR then RTS.
        send(OP_JSR, 32'h0000_1000, 4'd4, 16'h0, 16'h0, 32'h7000, 1'b1, 32'h7000);
        check("t4_bu_jsr", bu_opcode, OP_JSR);
        step();
        step();
        check("t4_jsr_valid", redirect_valid, 1);
        check("t4_jsr_pc", redirect_pc, 32'h7000);
        check("t4_jsr_ras", ras_count, 1);
        step();
        send(OP_RTS, 32'h0000_7010, 4'd2, 16'h0, 16'h0, 32'h0, 1'b0, 32'hDEAD_0000);
        check("t4_bu_rts_nop", bu_opcode, OP_NOP);
        step();
        step();
        check("t4_rts_valid", redirect_valid, 1);
        check("t4_rts_pc", redirect_pc, 32'h1004);
        check("t4_rts_ras", ras_count, 0);
        check("t4_taken_cnt", taken_cnt, 3);
        step();

        // RTS with an empty stack.
        send(OP_RTS, 32'h0000_2000, 4'd2, 16'h0, 16'h0, 32'h0, 1'b0, 32'h0);
        step();
        step();
        check("t5_underflow", ras_underflow, 1);
        check("t5_no_redirect", redirect_valid, 0);
        check("t5_ex_ready", ex_ready, 1);
        step();
        check("t5_underflow_pulse", ras_underflow, 0);

        // Nine JSRs into an 8-deep stack.
        for (int i = 1; i <= 9; i++) begin
            ret[i] = 32'h100 * i + i;
            send(OP_JSR, 32'h100 * i, 4'(i), 16'h0, 16'h0, 32'h9000 + i, 1'b1, 32'h9000 + i);
            step();
            step();
            check($sformatf("t5_jsr%0d_pc", i), redirect_pc, 32'h9000 + i);
            check($sformatf("t5_jsr%0d_ovf", i), ras_overflow, (i == 9) ? 1 : 0);
            check($sformatf("t5_jsr%0d_cnt", i), ras_count, (i > 8) ? 8 : i);
            step();
            check($sformatf("t5_jsr%0d_ovf_end", i), ras_overflow, 0);
        end
        for (int k = 0; k < 8; k++) begin
            send(OP_RTS, 32'h0000_8000, 4'd2, 16'h0, 16'h0, 32'h0, 1'b0, 32'h0);
            step();
            step();
            check($sformatf("t5_rts%0d_valid", k), redirect_valid, 1);
            check($sformatf("t5_rts%0d_pc", k), redirect_pc, ret[9 - k]);
            check($sformatf("t5_rts%0d_cnt", k), ras_count, 7 - k);
            step();
        end
        check("t5_taken_cnt", taken_cnt, 20);

        // Redirect stalled for five cycles while execute presents a request.
        redirect_ready = 1'b0;
        send(OP_B, 32'h0000_4000, 4'd2, 16'h0, 16'h0, 32'h4444, 1'b1, 32'h4444);
        ex_opcode = OP_BNE;
        ex_target = 32'h5555;
        ex_valid  = 1'b1;
        step();
        step();
        check("t6_flush_first", flush, 1);
        check("t6_valid_first", redirect_valid, 1);
        check("t6_pc_first", redirect_pc, 32'h4444);
        for (int c = 1; c < 5; c++) begin
            step();
            check($sformatf("t6_flush_c%0d", c), flush, 0);
            check($sformatf("t6_valid_c%0d", c), redirect_valid, 1);
            check($sformatf("t6_pc_c%0d", c), redirect_pc, 32'h4444);
            check($sformatf("t6_ex_ready_c%0d", c), ex_ready, 0);
        end
        redirect_ready = 1'b1;
        step();
        check("t6_valid_done", redirect_valid, 0);
        check("t6_ex_ready_done", ex_ready, 1);
        check("t6_bu_not_replaced", bu_opcode, OP_B);
        check("t6_bu_target_kept", bu_target, 32'h4444);
        check("t6_taken_cnt", taken_cnt, 21);
        ex_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
